// File: rtl/piso_serializer_if.sv
// Word handshake between a producing datapath and the serializer.
// A word moves on a rising edge where in_valid && in_ready are both high. The producer
// holds in_data and in_valid stable until that edge.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a one-word holding buffer.
// Bits leave on ser_out one per shift_en strobe. Back-to-back words stream without a gap.
module piso_serializer #(
    parameter int WIDTH      = 8,
    parameter bit LSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    piso_serializer_if.slave   in_if,
    input  logic               shift_en,
    output logic               ser_out,
    output logic               busy,
    output logic               frame_done,
    output logic               state_dbg
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] hold_buf_q, hold_buf_d;
    logic             hold_full_q, hold_full_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             ser_q, ser_d;
    logic             out_bit;
    logic [WIDTH-1:0] shreg_shifted;
    logic             accept;

    // in_ready comes only from the registered flag, so a drain never accepts in the same cycle.
    assign in_if.in_ready = !hold_full_q && !reset;
    assign accept         = in_if.in_valid && in_if.in_ready;

    assign out_bit       = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
    assign shreg_shifted = LSB_FIRST ? {IDLE_LEVEL, shreg_q[WIDTH-1:1]}
                                     : {shreg_q[WIDTH-2:0], IDLE_LEVEL};

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        hold_buf_d  = hold_buf_q;
        hold_full_d = hold_full_q;
        bit_cnt_d   = bit_cnt_q;
        ser_d       = ser_q;
        frame_done  = 1'b0;

        if (accept) begin
            hold_buf_d  = in_if.in_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (shift_en) begin
                    ser_d = IDLE_LEVEL;
                end
                if (hold_full_q) begin
                    shreg_d     = hold_buf_q;
                    hold_full_d = 1'b0;
                    bit_cnt_d   = '0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    ser_d     = out_bit;
                    shreg_d   = shreg_shifted;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_CNT) begin
                        // An aborted word must not report completion.
                        frame_done = !reset;
                        bit_cnt_d  = '0;
                        if (hold_full_q) begin
                            shreg_d     = hold_buf_q;
                            hold_full_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            hold_buf_q  <= '0;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= '0;
            ser_q       <= IDLE_LEVEL;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            hold_buf_q  <= hold_buf_d;
            hold_full_q <= hold_full_d;
            bit_cnt_q   <= bit_cnt_d;
            ser_q       <= ser_d;
        end
    end

    assign ser_out   = ser_q;
    assign busy      = (state_q == SHIFT);
    assign state_dbg = state_q;
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parametrised parallel-in/serial-out serializer with a valid/ready input and a one-word holding buffer.
- Each accepted word is shifted out one bit per shift strobe, in a configurable bit order.
- Back-to-back words stream with no idle gap.
- Sits between a word-producing datapath and a single-wire serial link.
- Bit timing is set externally by a shift_en strobe, e.g. a baud tick.

Parameters:
WIDTH, 8, bits per word; must be at least 2.
LSB_FIRST, 1, 1 = bit 0 is transmitted first; 0 = bit WIDTH-1 is transmitted first.
IDLE_LEVEL, 1, level driven on ser_out when no word is being transmitted.

Ports:
clk  input  1  clock, all state updates on rising edge.
reset  input  1  synchronous, active-high.
in_data  input  WIDTH  parallel word to serialize.
in_valid  input  1  in_data is valid.
in_ready  output  1  holding buffer empty; word accepted when in_valid && in_ready at a rising edge.
shift_en  input  1  bit-rate strobe; one bit period per asserted cycle.
ser_out  output  1  registered serial output.
busy  output  1  high while in state SHIFT.
frame_done  output  1  one-cycle pulse on the edge where the last bit of a word is driven onto ser_out.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values:
  - shift register 0, hold buffer empty, bit counter 0, state IDLE.
  - ser_out = IDLE_LEVEL, busy = 0, frame_done = 0.
  - in_ready is forced 0 while reset is high.
- in_ready:
  - Equals NOT hold_full, taken from the registered flag only. No same-cycle pass-through.
  - A word offered while in_ready = 0 is ignored. The producer must hold in_data and in_valid stable.
- Accept: on in_valid && in_ready, hold_buf <= in_data and hold_full <= 1.
- State IDLE:
  - If hold_full: shreg <= hold_buf, hold_full <= 0, bit_cnt <= 0, go to SHIFT. This is one cycle after accept.
  - ser_out does not change on the load edge.
  - On any shift_en in IDLE, ser_out <= IDLE_LEVEL.
- State SHIFT, on each shift_en:
  - ser_out <= shreg[0] if LSB_FIRST, else shreg[WIDTH-1].
  - shreg shifts one position toward the output end, filling the vacated end with IDLE_LEVEL.
  - bit_cnt increments.
- No shift_en means state holds, with no change to ser_out, shreg or bit_cnt.
- Last bit (bit_cnt == WIDTH-1 with shift_en):
  - frame_done = 1 for that cycle.
  - If hold_full: reload shreg from hold_buf, clear hold_full, bit_cnt <= 0, stay in SHIFT. The next word's first bit goes out on the next shift_en with no gap.
  - Otherwise go to IDLE. The last bit is held on ser_out until the next shift_en, which drives IDLE_LEVEL.
- Accept and drain cannot coincide: in_ready is low whenever hold_full is set.
- Latency: a word accepted at edge N is loaded at edge N+1. Its first bit appears on ser_out at the first shift_en edge after N+1.
- Reset mid-frame:
  - The current word and the pending word are both discarded.
  - ser_out = IDLE_LEVEL at the reset edge.
  - frame_done is not pulsed for the aborted word.
- bit_cnt width is $clog2(WIDTH). There is no wrap beyond WIDTH-1.

Test Plan:
1. WIDTH=8, LSB_FIRST=1, IDLE_LEVEL=1, shift_en tied high, send 0x01 -> ser_out 1,0,0,0,0,0,0,0 on 8 consecutive cycles, then 1. frame_done high only on the 8th bit; busy high for exactly 8 cycles.
2. Same config with LSB_FIRST=0, send 0x01 -> ser_out 0 for 7 cycles, then 1, then IDLE_LEVEL 1.
3. Back-to-back: send 0xA5, then 0x3C while 0xA5 is shifting -> 16 contiguous bits 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
   - in_ready stays 0 from the 0x3C accept until its reload.
   - Two frame_done pulses, 8 cycles apart.
4. shift_en asserted every 4th cycle, send 0x0F -> each bit held 4 cycles; frame_done coincides with the 8th strobe.
5. Backpressure: with hold_full=1, change in_data from 0x55 to 0xFF while in_valid is high -> only the word present at the accept edge is transmitted; no extra frame.
6. Reset asserted after 3 bits of 0xA5 with 0x3C pending -> next edge: ser_out=1, busy=0, in_ready=1 after release. No frame_done; neither word is transmitted.
